branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 16, meaning the number of BTB/BHT entries (power of two, minimum 4).
REQ-002 The module SHALL have parameter WIDTH, default 32, meaning the PC and target width.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port PCF  input  WIDTH  fetch-stage PC, used for lookup.
REQ-007 Port PredTakenF  output  1  fetch-stage prediction, taken.
REQ-008 Port PredTargetF  output  WIDTH  predicted target; valid when PredTakenF=1.
REQ-009 Port BranchE  input  1  a conditional branch is in execute.
REQ-010 Port BranchTakenE  input  1  resolved branch outcome.
REQ-011 Port PCE  input  WIDTH  execute-stage branch PC.
REQ-012 Port PCTargetE  input  WIDTH  resolved branch target.
REQ-013 Port PredTakenE  input  1  the prediction made for this branch, piped from F.
REQ-014 Port PredTargetE  input  WIDTH  the predicted target, piped from F.
REQ-015 Port flushBranch  output  1  mispredict; consumed by the hazard unit to flush F/D and D/E.
REQ-016 Port PCRedirectE  output  WIDTH  correct next PC; valid when flushBranch=1.
REQ-017 Port MissCount  output  16  saturating mispredict counter.

Function
REQ-018 Index SHALL be PC[log2(ENTRIES)+1:2], and tag SHALL be PC[WIDTH-1:log2(ENTRIES)+2]; bits [1:0] SHALL be ignored.
REQ-019 Each entry SHALL hold a valid bit, a tag, a target (WIDTH bits), and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-020 Lookup SHALL be combinational: hit = valid && tag match; PredTakenF = hit && ctr[1]; PredTargetF = stored target on a hit, else PCF+4.
REQ-021 flushBranch SHALL be combinational: BranchE && ((BranchTakenE != PredTakenE) || (BranchTakenE && PredTakenE && PredTargetE != PCTargetE)).
REQ-022 PCRedirectE SHALL equal PCTargetE when BranchTakenE=1, else PCE+4; arithmetic SHALL be modulo 2^WIDTH.
REQ-023 Update SHALL occur on the clk edge when BranchE=1, at the index of PCE.
REQ-024 On a tag hit: a taken branch SHALL increment ctr (saturating at 11) and write the target; a not-taken branch SHALL decrement ctr (saturating at 00).
REQ-025 On a miss with BranchTakenE=1: the entry SHALL be allocated (valid=1, tag, target) with ctr=10, overwriting any previous occupant.
REQ-026 On a miss with BranchTakenE=0: there SHALL be no allocation and no state change.
REQ-027 If PCF and PCE map to the same index in the same cycle, lookup SHALL return pre-update contents; the new state SHALL be visible the next cycle.
REQ-028 MissCount SHALL increment by 1 on each clk edge with flushBranch=1 and SHALL saturate at 16'hFFFF.
REQ-029 Updates SHALL NOT depend on the hazard unit's stall; the caller SHALL hold BranchE=0 for bubbles.

Reset
REQ-030 When rst_n=0, all valid bits SHALL clear, all ctr SHALL be set to 01, and MissCount SHALL be 0, immediately and regardless of clk.
REQ-031 While in reset, PredTakenF SHALL be 0 and PredTargetF SHALL be PCF+4; flushBranch and PCRedirectE SHALL still follow REQ-021/022 combinationally.
REQ-032 An update coinciding with reset assertion SHALL be discarded; the first update SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-033 Cold lookup: after reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-034 Allocate on taken: BranchE=1, PCE=0x100, BranchTakenE=1, PCTargetE=0x80, PredTakenE=0 -> flushBranch=1, PCRedirectE=0x80, and MissCount becomes 1. Then PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
REQ-035 Saturation and hysteresis: three taken resolutions at 0x100 give ctr=11. One not-taken then gives ctr=10 and PredTakenF stays 1. A second not-taken gives ctr=01 and PredTakenF=0.
REQ-036 Target mismatch: PredTakenE=1, PredTargetE=0x80, BranchTakenE=1, PCTargetE=0x90 -> flushBranch=1, PCRedirectE=0x90, and the entry target becomes 0x90.
REQ-037 Alias and same-cycle hazard: with ENTRIES=16, PCE=0x140 taken while PCF=0x100 (same index, different tag) -> the F lookup returns old data this cycle. The next cycle, 0x100 misses and 0x140 hits.
REQ-038 Reset mid-run: assert rst_n=0 between edges with entries valid and MissCount=5 -> PredTakenF=0 and MissCount=0 immediately; a not-taken miss after reset causes no allocation.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, plus execute-stage mispredict detection.
// Lookup is combinational; updates land on the clock edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             BranchE,
  input  logic             BranchTakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  output logic             flushBranch,
  output logic [WIDTH-1:0] PCRedirectE,
  output logic [15:0]      MissCount
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = WIDTH - IW - 2;

  logic             r_valid [ENTRIES];
  logic [TW-1:0]    r_tag   [ENTRIES];
  logic [WIDTH-1:0] r_tgt   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];

  logic [IW-1:0] w_fidx;
  logic [TW-1:0] w_ftag;
  logic          w_fhit;
  logic [IW-1:0] w_eidx;
  logic [TW-1:0] w_etag;
  logic          w_ehit;
  logic [1:0]    w_ectr;
  logic [1:0]    w_inc;
  logic [1:0]    w_dec;

  assign w_fidx = PCF[IW+1:2];
  assign w_ftag = PCF[WIDTH-1:IW+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

  assign PredTakenF  = w_fhit && r_ctr[w_fidx][1];
  assign PredTargetF = w_fhit ? r_tgt[w_fidx] : PCF + WIDTH'(4);

  assign w_eidx = PCE[IW+1:2];
  assign w_etag = PCE[WIDTH-1:IW+2];
  assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_ectr = r_ctr[w_eidx];
  assign w_inc  = (w_ectr == 2'b11) ? 2'b11 : w_ectr + 2'd1;
  assign w_dec  = (w_ectr == 2'b00) ? 2'b00 : w_ectr - 2'd1;

  // A taken branch whose target changed is a mispredict even if direction matched
  assign flushBranch = BranchE &&
    ((BranchTakenE != PredTakenE) ||
     (BranchTakenE && PredTakenE && (PredTargetE != PCTargetE)));

  assign PCRedirectE = BranchTakenE ? PCTargetE : PCE + WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (BranchE) begin
      if (w_ehit) begin
        if (BranchTakenE) begin
          r_ctr[w_eidx] <= w_inc;
          r_tgt[w_eidx] <= PCTargetE;
        end else begin
          r_ctr[w_eidx] <= w_dec;
        end
      end else if (BranchTakenE) begin
        r_valid[w_eidx] <= 1'b1;
        r_tag[w_eidx]   <= w_etag;
        r_tgt[w_eidx]   <= PCTargetE;
        r_ctr[w_eidx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MissCount <= '0;
    end else if (flushBranch && (MissCount != 16'hFFFF)) begin
      MissCount <= MissCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset sequence,
// then randomized traffic against an associative-array reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        BranchTakenE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        flushBranch;
  logic [31:0] PCRedirectE;
  logic [15:0] MissCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PCF(PCF),
    .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF),
    .BranchE(BranchE),
    .BranchTakenE(BranchTakenE),
    .PCE(PCE),
    .PCTargetE(PCTargetE),
    .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE),
    .flushBranch(flushBranch),
    .PCRedirectE(PCRedirectE),
    .MissCount(MissCount)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic be, input logic bt, input logic [31:0] pce,
                       input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptgt, input logic [31:0] pcf);
    BranchE      = be;
    BranchTakenE = bt;
    PCE          = pce;
    PCTargetE    = tgt;
    PredTakenE   = pt;
    PredTargetE  = ptgt;
    PCF          = pcf;
  endtask

  typedef struct {
    logic        be;
    logic        bt;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] pcf;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_flush;
    logic [31:0] e_redir;
    logic [15:0] e_miss;
  } vec_t;

  vec_t vt[15];

  // Reference model: map index -> entry; presence means valid
  typedef struct {
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ment_t;

  ment_t m[int];
  int    m_miss;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    int i = m_idx(pc);
    return m.exists(i) && (m[i].tag == pc / 64);
  endfunction

  function automatic logic m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m[m_idx(pc)].ctr >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_hit(pc) ? m[m_idx(pc)].tgt : pc + 32'd4;
  endfunction

  function automatic logic m_flush(input logic be, input logic bt,
                                   input logic pt, input logic [31:0] ptgt,
                                   input logic [31:0] tgt);
    if (!be) return 1'b0;
    if (bt != pt) return 1'b1;
    return bt && (ptgt != tgt);
  endfunction

  task automatic m_update(input logic be, input logic bt,
                          input logic [31:0] pce, input logic [31:0] tgt,
                          input logic fl);
    int i = m_idx(pce);
    if (fl && m_miss < 65535) m_miss++;
    if (!be) return;
    if (m_hit(pce)) begin
      if (bt) begin
        m[i].ctr = (m[i].ctr < 3) ? m[i].ctr + 1 : 3;
        m[i].tgt = tgt;
      end else begin
        m[i].ctr = (m[i].ctr > 0) ? m[i].ctr - 1 : 0;
      end
    end else if (bt) begin
      m[i] = '{tag: pce / 64, tgt: tgt, ctr: 2};
    end
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] t = 32'($urandom_range(0, 3));
    logic [31:0] x = 32'($urandom_range(0, 15));
    logic [31:0] b = 32'($urandom_range(0, 3));
    return 32'h1000 + t * 64 + x * 4 + b;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //        be bt pce      tgt      pt ptgt     pcf       ept eptgt   efl eredir  miss
    vt[0]  = '{0, 0, 32'h0,   32'h0,   0, 32'h0,  32'h100, 0, 32'h104, 0, 32'h4,   16'd0};
    vt[1]  = '{1, 1, 32'h100, 32'h80,  0, 32'h0,  32'h100, 0, 32'h104, 1, 32'h80,  16'd1};
    vt[2]  = '{0, 0, 32'h100, 32'h0,   0, 32'h0,  32'h100, 1, 32'h80,  0, 32'h104, 16'd1};
    vt[3]  = '{1, 1, 32'h100, 32'h80,  1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  16'd1};
    vt[4]  = '{1, 1, 32'h100, 32'h80,  1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  16'd1};
    vt[5]  = '{1, 1, 32'h100, 32'h80,  1, 32'h80, 32'h100, 1, 32'h80,  0, 32'h80,  16'd1};
    vt[6]  = '{1, 0, 32'h100, 32'h80,  1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h104, 16'd2};
    vt[7]  = '{1, 0, 32'h100, 32'h80,  1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h104, 16'd3};
    vt[8]  = '{0, 0, 32'h100, 32'h0,   0, 32'h0,  32'h100, 0, 32'h80,  0, 32'h104, 16'd3};
    vt[9]  = '{1, 1, 32'h100, 32'h80,  0, 32'h0,  32'h100, 0, 32'h80,  1, 32'h80,  16'd4};
    vt[10] = '{1, 1, 32'h100, 32'h90,  1, 32'h80, 32'h100, 1, 32'h80,  1, 32'h90,  16'd5};
    vt[11] = '{0, 0, 32'h100, 32'h0,   0, 32'h0,  32'h100, 1, 32'h90,  0, 32'h104, 16'd5};
    vt[12] = '{1, 1, 32'h140, 32'h200, 0, 32'h0,  32'h100, 1, 32'h90,  1, 32'h200, 16'd6};
    vt[13] = '{0, 0, 32'h140, 32'h0,   0, 32'h0,  32'h100, 0, 32'h104, 0, 32'h144, 16'd6};
    vt[14] = '{0, 0, 32'h140, 32'h0,   0, 32'h0,  32'h140, 1, 32'h200, 0, 32'h144, 16'd6};

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      @(negedge clk);
      drive(vt[k].be, vt[k].bt, vt[k].pce, vt[k].tgt,
            vt[k].pt, vt[k].ptgt, vt[k].pcf);
      #1;
      chk($sformatf("v%0d PredTakenF", k), 32'(PredTakenF), 32'(vt[k].e_pt));
      chk($sformatf("v%0d PredTargetF", k), PredTargetF, vt[k].e_ptgt);
      chk($sformatf("v%0d flushBranch", k), 32'(flushBranch), 32'(vt[k].e_flush));
      chk($sformatf("v%0d PCRedirectE", k), PCRedirectE, vt[k].e_redir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d MissCount", k), 32'(MissCount), 32'(vt[k].e_miss));
    end

    // Mid-run reset with a valid entry at 0x140 and a taken update pending
    @(negedge clk);
    drive(1, 1, 32'h140, 32'h300, 0, 32'h0, 32'h140);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst PredTakenF", 32'(PredTakenF), 32'd0);
    chk("rst PredTargetF", PredTargetF, 32'h144);
    chk("rst MissCount", 32'(MissCount), 32'd0);
    chk("rst flushBranch", 32'(flushBranch), 32'd1);
    chk("rst PCRedirectE", PCRedirectE, 32'h300);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h140, 32'h0, 0, 32'h0, 32'h140);
    #1;
    chk("post-rst discard PredTakenF", 32'(PredTakenF), 32'd0);
    chk("post-rst discard PredTargetF", PredTargetF, 32'h144);
    chk("post-rst MissCount", 32'(MissCount), 32'd0);
    @(negedge clk);
    drive(1, 0, 32'h140, 32'h500, 0, 32'h0, 32'h140);
    #1;
    chk("nt-miss flushBranch", 32'(flushBranch), 32'd0);
    @(negedge clk);
    drive(0, 0, 32'h140, 32'h0, 0, 32'h0, 32'h140);
    #1;
    chk("nt-miss no alloc PredTargetF", PredTargetF, 32'h144);
    chk("nt-miss MissCount", 32'(MissCount), 32'd0);
    drive(1, 1, 32'h140, 32'h600, 0, 32'h0, 32'h140);
    @(negedge clk);
    drive(0, 0, 32'h140, 32'h0, 0, 32'h0, 32'h140);
    #1;
    chk("first update PredTakenF", 32'(PredTakenF), 32'd1);
    chk("first update PredTargetF", PredTargetF, 32'h600);
    chk("first update MissCount", 32'(MissCount), 32'd1);

    // Randomized traffic against the reference model from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    m.delete();
    m_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic        be, bt, pt, fl;
      logic [31:0] pce, tgt, ptgt, pcf;
      @(negedge clk);
      be  = ($urandom_range(0, 3) != 0);
      bt  = 1'($urandom_range(0, 1));
      pce = rpc();
      pcf = ($urandom_range(0, 3) == 0) ? pce : rpc();
      tgt = 32'h2000 + 32'($urandom_range(0, 7)) * 16;
      if ($urandom_range(0, 1) == 1) begin
        pt   = m_ptaken(pce);
        ptgt = m_ptgt(pce);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = 32'h2000 + 32'($urandom_range(0, 7)) * 16;
      end
      drive(be, bt, pce, tgt, pt, ptgt, pcf);
      #1;
      fl = m_flush(be, bt, pt, ptgt, tgt);
      chk("rnd PredTakenF", 32'(PredTakenF), 32'(m_ptaken(pcf)));
      chk("rnd PredTargetF", PredTargetF, m_ptgt(pcf));
      chk("rnd flushBranch", 32'(flushBranch), 32'(fl));
      chk("rnd PCRedirectE", PCRedirectE, bt ? tgt : pce + 32'd4);
      @(posedge clk);
      m_update(be, bt, pce, tgt, fl);
      #1;
      chk("rnd MissCount", 32'(MissCount), 32'(m_miss));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
